// File: rtl/dsp_result_drain.sv
// Result drain for a DSP48A1 slice: tags each issue through the fixed slice latency, captures P into a
// first-word fall-through FIFO and throttles issue by credit. Define DSP_DRAIN_FLUSH_EN for a synchronous flush input.
module dsp_result_drain #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef DSP_DRAIN_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     issue,
    input  logic [WIDTH-1:0]         slice_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [LATENCY-1:0] r_tag;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic [LW-1:0]      r_credit;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_flush;
    logic               w_capture;
    logic               w_pop;
    logic [LW-1:0]      w_level_nxt;
    logic [LW-1:0]      w_credit_nxt;

`ifdef DSP_DRAIN_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // in_ready comes from a register, so out_ready never reaches it combinationally.
    assign in_ready  = r_in_ready && !w_flush;
    assign issue     = in_valid && in_ready;
    assign w_capture = r_tag[LATENCY-1];
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign level     = r_level;

    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    always_comb begin
        w_level_nxt  = r_level;
        w_credit_nxt = r_credit;
        case ({w_capture, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
        case ({issue, w_pop})
            2'b10:   w_credit_nxt = r_credit + LW'(1);
            2'b01:   w_credit_nxt = r_credit - LW'(1);
            default: w_credit_nxt = r_credit;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_credit   <= '0;
            r_in_ready <= 1'b1;
        end else if (w_flush) begin
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_credit   <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_tag[0] <= issue;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_capture) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level    <= w_level_nxt;
            r_credit   <= w_credit_nxt;
            r_in_ready <= (w_credit_nxt < DEPTH_L);
        end
    end

    // NOTE: the result store has no reset; contents are only visible once level marks them valid.
    always_ff @(posedge clk) begin
        if (w_capture && !w_flush) begin
            r_mem[r_wr_ptr] <= slice_p;
        end
    end

endmodule
